// File: rtl/regfile_wb.sv
// Write-side sequencer for the 32x32 register file: merges ALU and buffered load results onto
// the single write port and tracks a per-register busy scoreboard for RAW stalls.
module regfile_wb #(
    parameter int unsigned LD_DEPTH  = 4,
    parameter int unsigned MAX_DEFER = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_i_issue_valid,
    input  logic [4:0]  wb_i_issue_rd,
    input  logic [4:0]  wb_i_src_a,
    input  logic [4:0]  wb_i_src_b,
    output logic        wb_o_stall,
    input  logic        wb_i_alu_valid,
    input  logic [4:0]  wb_i_alu_rd,
    input  logic [31:0] wb_i_alu_data,
    output logic        wb_o_alu_hold,
    input  logic        wb_i_ld_valid,
    output logic        wb_o_ld_ready,
    input  logic [4:0]  wb_i_ld_rd,
    input  logic [31:0] wb_i_ld_data,
    output logic [4:0]  wb_o_rf_write_reg,
    output logic [31:0] wb_o_rf_write_data,
    output logic [31:0] wb_o_busy,
    output logic        wb_o_idle,
    output logic        wb_o_err
);

    localparam int unsigned PW = $clog2(LD_DEPTH);
    localparam int unsigned DW = $clog2(MAX_DEFER + 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(LD_DEPTH);
    localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);

    logic [4:0]    r_fifo_rd   [LD_DEPTH];
    logic [31:0]   r_fifo_data [LD_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [DW-1:0] r_defer;
    logic          r_alu_hold;
    logic          r_err;
    logic [4:0]    r_write_reg;
    logic [31:0]   r_write_data;
    logic [31:0]   r_busy;

    logic          w_empty;
    logic          w_full;
    logic          w_ld_ready;
    logic          w_alu_win;
    logic          w_pop;
    logic          w_push;
    logic [PW:0]   w_count_d;
    logic [DW-1:0] w_defer_d;
    logic          w_hold_d;
    logic [4:0]    w_write_reg_d;
    logic [31:0]   w_write_data_d;
    logic [31:0]   w_busy_d;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    // Ready is based on pre-pop occupancy, so a full FIFO refuses even while popping.
    assign w_ld_ready = rst_n && !w_full;
    assign w_alu_win  = wb_i_alu_valid && (wb_i_alu_rd != 5'd0);
    assign w_pop      = !w_alu_win && !w_empty;
    assign w_push     = wb_i_ld_valid && w_ld_ready && (wb_i_ld_rd != 5'd0);
    assign w_count_d  = r_count + (PW + 1)'(w_push) - (PW + 1)'(w_pop);

    always_comb begin
        w_defer_d = '0;
        if (w_alu_win && !w_empty) begin
            w_defer_d = (r_defer == DEFER_MAX) ? r_defer : r_defer + 1'b1;
        end
    end

    assign w_hold_d = (w_defer_d >= DEFER_MAX) || (w_count_d == FULL_CNT);

    always_comb begin
        w_write_reg_d  = '0;
        w_write_data_d = '0;
        if (w_alu_win) begin
            w_write_reg_d  = wb_i_alu_rd;
            w_write_data_d = wb_i_alu_data;
        end else if (!w_empty) begin
            w_write_reg_d  = r_fifo_rd[r_rd_ptr];
            w_write_data_d = r_fifo_data[r_rd_ptr];
        end
    end

    // Clear for the register being written this edge; a same-edge issue re-sets it.
    always_comb begin
        w_busy_d = r_busy;
        if (r_write_reg != 5'd0) begin
            w_busy_d[r_write_reg] = 1'b0;
        end
        if (wb_i_issue_valid && (wb_i_issue_rd != 5'd0)) begin
            w_busy_d[wb_i_issue_rd] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= wb_i_ld_rd;
            r_fifo_data[r_wr_ptr] <= wb_i_ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_defer      <= '0;
            r_alu_hold   <= 1'b0;
            r_err        <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_busy       <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count      <= w_count_d;
            r_defer      <= w_defer_d;
            r_alu_hold   <= w_hold_d;
            if (w_alu_win && r_alu_hold) r_err <= 1'b1;
            r_write_reg  <= w_write_reg_d;
            r_write_data <= w_write_data_d;
            r_busy       <= w_busy_d;
        end
    end

    assign wb_o_stall = ((wb_i_src_a != 5'd0) && r_busy[wb_i_src_a]) ||
                        ((wb_i_src_b != 5'd0) && r_busy[wb_i_src_b]);
    assign wb_o_ld_ready      = w_ld_ready;
    assign wb_o_alu_hold      = r_alu_hold;
    assign wb_o_rf_write_reg  = r_write_reg;
    assign wb_o_rf_write_data = r_write_data;
    assign wb_o_busy          = r_busy;
    assign wb_o_idle          = (r_busy == '0) && w_empty && (r_write_reg == 5'd0);
    assign wb_o_err           = r_err;

endmodule
